// File: rtl/stereo_pkg.sv
// Shared definitions for the stereo disparity engine.
// Holds the controller state encoding, the default parameter values and
// the width helpers used to size the buffers, counters and SAD datapath.
package stereo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_PIX_W    = 8;
    localparam int DEF_WIN      = 5;
    localparam int DEF_MAX_DISP = 64;

    // Ceiling log2; clog2_w(1) = 0.
    function automatic int clog2_w(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int disp_w(input int max_disp);
        return clog2_w(max_disp + 1);
    endfunction

    // Wide enough that WIN*WIN maximal differences cannot overflow.
    function automatic int sad_w(input int pix_w, input int win);
        return pix_w + clog2_w(win * win);
    endfunction

    function automatic int col_w(input int max_disp, input int win);
        return clog2_w(max_disp + win);
    endfunction

    function automatic int row_w(input int win);
        return clog2_w(win);
    endfunction

endpackage

// File: rtl/disparity_engine_if.sv
// Buffer-write and search-control bus of the disparity engine.
//   master : drives ref/srch write strobes, col/row/pix, start_in
//   slave  : drives busy_out, done_out, disparity_out, min_sad_out
interface disparity_engine_if #(
    parameter int PIX_W    = stereo_pkg::DEF_PIX_W,
    parameter int WIN      = stereo_pkg::DEF_WIN,
    parameter int MAX_DISP = stereo_pkg::DEF_MAX_DISP
);
    localparam int DISP_W = stereo_pkg::disp_w(MAX_DISP);
    localparam int SAD_W  = stereo_pkg::sad_w(PIX_W, WIN);
    localparam int COL_W  = stereo_pkg::col_w(MAX_DISP, WIN);
    localparam int ROW_W  = stereo_pkg::row_w(WIN);

    logic              ref_we_in;
    logic              srch_we_in;
    logic [COL_W-1:0]  col_in;
    logic [ROW_W-1:0]  row_in;
    logic [PIX_W-1:0]  pix_in;
    logic              start_in;
    logic              busy_out;
    logic              done_out;
    logic [DISP_W-1:0] disparity_out;
    logic [SAD_W-1:0]  min_sad_out;

    modport master (
        output ref_we_in, srch_we_in, col_in, row_in, pix_in, start_in,
        input  busy_out, done_out, disparity_out, min_sad_out
    );

    modport slave (
        input  ref_we_in, srch_we_in, col_in, row_in, pix_in, start_in,
        output busy_out, done_out, disparity_out, min_sad_out
    );

endinterface

// File: rtl/sad_tree.sv
// Combinational sum of absolute differences over one WIN x WIN window.
//   ref_win  : reference window pixels, flattened col*WIN+row
//   srch_win : search window pixels at the current candidate offset
//   sad_out  : sum of |ref - srch|, SAD_W wide
module sad_tree #(
    parameter int PIX_W = 8,
    parameter int WIN   = 5,
    parameter int SAD_W = 13
) (
    input  logic [PIX_W-1:0] ref_win  [WIN*WIN],
    input  logic [PIX_W-1:0] srch_win [WIN*WIN],
    output logic [SAD_W-1:0] sad_out
);

    // Written as a linear sum; synthesis rebalances it into a tree.
    always_comb begin
        sad_out = '0;
        for (int i = 0; i < WIN * WIN; i++) begin
            sad_out = sad_out + SAD_W'((ref_win[i] > srch_win[i]) ?
                                       (ref_win[i] - srch_win[i]) :
                                       (srch_win[i] - ref_win[i]));
        end
    end

endmodule

// File: rtl/disparity_engine.sv
// Block-matching disparity search: evaluates SAD for every candidate
// 0..MAX_DISP between the reference window and the search strip, and
// reports the lowest-SAD candidate (lowest index wins on ties).
//   clk_in, rst_in : clock, asynchronous active-low reset
//   bus (slave)    : buffer writes, start/busy/done, result outputs
//
// state | meaning
// IDLE  | waiting for start_in, buffers writable
// RUN   | one candidate per cycle: register SAD(d), d++
// FLUSH | compare the last registered candidate
// DONE  | publish result, pulse done_out, drop busy_out
module disparity_engine
    import stereo_pkg::*;
#(
    parameter int PIX_W    = DEF_PIX_W,
    parameter int WIN      = DEF_WIN,
    parameter int MAX_DISP = DEF_MAX_DISP
) (
    input  logic              clk_in,
    input  logic              rst_in,
    disparity_engine_if.slave bus
);

    localparam int DISP_W = disp_w(MAX_DISP);
    localparam int SAD_W  = sad_w(PIX_W, WIN);
    localparam int COL_W  = col_w(MAX_DISP, WIN);
    localparam int ROW_W  = row_w(WIN);
    localparam int NCOL   = MAX_DISP + WIN;
    localparam int NPIX   = WIN * WIN;

    logic [PIX_W-1:0]  ref_mem  [WIN][WIN];
    logic [PIX_W-1:0]  srch_mem [NCOL][WIN];
    logic [PIX_W-1:0]  ref_win  [NPIX];
    logic [PIX_W-1:0]  srch_win [NPIX];
    logic [SAD_W-1:0]  sad_comb;

    state_t            state;
    logic [DISP_W-1:0] d_cnt;
    logic [DISP_W-1:0] d_q;
    logic [SAD_W-1:0]  sad_q;
    logic              sad_vld;
    logic [DISP_W-1:0] best_d;
    logic [SAD_W-1:0]  best_sad;
    logic              busy_q;
    logic              done_q;
    logic [DISP_W-1:0] disp_q;
    logic [SAD_W-1:0]  min_sad_q;
    logic              ref_ok;
    logic              srch_ok;

    assign ref_ok  = bus.ref_we_in && !busy_q &&
                     (int'(bus.col_in) < WIN) && (int'(bus.row_in) < WIN);
    assign srch_ok = bus.srch_we_in && !busy_q &&
                     (int'(bus.col_in) < NCOL) && (int'(bus.row_in) < WIN);

    // Buffers are deliberately not reset; contents survive a reset.
    // After the range check the low ROW_W bits index the reference columns.
    always_ff @(posedge clk_in) begin
        if (ref_ok)
            ref_mem[bus.col_in[ROW_W-1:0]][bus.row_in] <= bus.pix_in;
        if (srch_ok)
            srch_mem[bus.col_in][bus.row_in] <= bus.pix_in;
    end

    always_comb begin
        for (int c = 0; c < WIN; c++) begin
            for (int r = 0; r < WIN; r++) begin
                ref_win[c*WIN + r]  = ref_mem[c][r];
                srch_win[c*WIN + r] = srch_mem[COL_W'(c) + COL_W'(d_cnt)][r];
            end
        end
    end

    sad_tree #(
        .PIX_W (PIX_W),
        .WIN   (WIN),
        .SAD_W (SAD_W)
    ) u_sad_tree (
        .ref_win  (ref_win),
        .srch_win (srch_win),
        .sad_out  (sad_comb)
    );

    // The compare stage runs one cycle behind the SAD register, which is
    // why FLUSH exists: the candidate registered on the last RUN cycle
    // still needs its compare.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state     <= ST_IDLE;
            d_cnt     <= '0;
            d_q       <= '0;
            sad_q     <= '0;
            sad_vld   <= 1'b0;
            best_d    <= '0;
            best_sad  <= '1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            disp_q    <= '0;
            min_sad_q <= '1;
        end else begin
            done_q  <= 1'b0;
            sad_vld <= 1'b0;

            // Strictly-less keeps the earlier (lower) disparity on ties.
            if (sad_vld && (sad_q < best_sad)) begin
                best_sad <= sad_q;
                best_d   <= d_q;
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start_in) begin
                        state    <= ST_RUN;
                        d_cnt    <= '0;
                        best_sad <= '1;
                        best_d   <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sad_q   <= sad_comb;
                    d_q     <= d_cnt;
                    sad_vld <= 1'b1;
                    if (d_cnt == DISP_W'(MAX_DISP))
                        state <= ST_FLUSH;
                    else
                        d_cnt <= d_cnt + 1'b1;
                end
                ST_FLUSH: begin
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    disp_q    <= best_d;
                    min_sad_q <= best_sad;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.disparity_out = disp_q;
    assign bus.min_sad_out   = min_sad_q;

endmodule

// File: doc/disparity_engine.md
DISPARITY_ENGINE -- requirements
Module: disparity_engine

Interface
REQ-001 SHALL expose parameter PIX_W, default 8, pixel width in bits.
REQ-002 SHALL expose parameter WIN, default 5, square window edge; odd values 3..9 only.
REQ-003 SHALL expose parameter MAX_DISP, default 64, highest candidate disparity; candidates are 0..MAX_DISP.
REQ-004 SHALL derive DISP_W = clog2(MAX_DISP+1), SAD_W = PIX_W + clog2(WIN*WIN), COL_W = clog2(MAX_DISP+WIN) and ROW_W = clog2(WIN) as localparams.
REQ-005 clk_in  input  1  single clock; all state changes on rising edge.
REQ-006 rst_in  input  1  asynchronous, active-low reset.
REQ-007 ref_we_in  input  1  write strobe for reference-window buffer.
REQ-008 srch_we_in  input  1  write strobe for search-strip buffer.
REQ-009 col_in  input  COL_W  column index of the write.
REQ-010 row_in  input  ROW_W  row index of the write.
REQ-011 pix_in  input  PIX_W  write data.
REQ-012 start_in  input  1  request one disparity search.
REQ-013 busy_out  output  1  search in progress.
REQ-014 done_out  output  1  one-cycle completion pulse.
REQ-015 disparity_out  output  DISP_W  winning candidate index.
REQ-016 min_sad_out  output  SAD_W  SAD of winning candidate.

Function
REQ-017 Buffers SHALL be synchronous, clk_in-clocked: reference WIN x WIN, search (MAX_DISP+WIN) x WIN.
REQ-018 Writes SHALL be accepted only when busy_out=0; writes while busy, or with col/row out of range, SHALL be dropped.
REQ-019 If ref_we_in and srch_we_in are both high in one cycle, both SHALL be written.
REQ-020 States SHALL be IDLE, RUN, FLUSH and DONE; reset state SHALL be IDLE.
REQ-021 IDLE->RUN SHALL occur on start_in=1; on entry, candidate counter d=0, best SAD=all-ones, busy_out=1.
REQ-022 In RUN, each cycle SHALL register SAD(d) = sum over c,r of |ref[c][r] - srch[c+d][r]| together with d, then increment d; after d=MAX_DISP, RUN->FLUSH.
REQ-023 The compare stage SHALL take the registered SAD and replace best on strictly less-than; ties SHALL keep the lower disparity.
REQ-024 FLUSH SHALL compare the final registered candidate, then go to DONE.
REQ-025 DONE SHALL, for one cycle, update disparity_out and min_sad_out, pulse done_out, clear busy_out and return to IDLE.
REQ-026 done_out SHALL rise exactly MAX_DISP+3 cycles after the edge sampling start_in.
REQ-027 disparity_out and min_sad_out SHALL hold their last result until the next DONE.
REQ-028 start_in while busy SHALL be ignored; start_in in DONE SHALL be ignored.
REQ-029 Absolute differences SHALL be unsigned PIX_W; the adder tree SHALL be SAD_W wide, with no overflow possible.

Reset
REQ-030 Reset SHALL force state=IDLE, busy_out=0, done_out=0, disparity_out=0, min_sad_out=all-ones and d=0, mid-run included; no result SHALL be produced for an aborted search.
REQ-031 Buffer contents SHALL NOT be reset; they are undefined until written.

Structure
REQ-032 Package stereo_pkg SHALL hold the state enum, the default parameter values and the clog2 width helper functions.
REQ-033 The WIN*WIN absolute-difference plus adder tree SHALL be sub-module sad_tree, combinational, with the output register in disparity_engine.

Verification (WIN=5, MAX_DISP=64, PIX_W=8)
REQ-034 Reference all 10, search all 10 except columns 20..24 = 200 -> disparity 0, SAD 0, done 67 cycles after start.
REQ-035 Reference random; search columns d+0..d+4 equal to reference for d=37, other columns reference+50 saturated -> disparity 37, SAD 0.
REQ-036 All pixels equal (ties everywhere) -> disparity 0; reference 0 with search 255 -> SAD 6375 (25*255), disparity 0.
REQ-037 Pulse start mid-run and write the reference mid-run -> result unchanged vs. the undisturbed run, single done pulse.
REQ-038 Assert rst_in low at RUN cycle 30 -> busy_out=0, disparity_out=0, min_sad_out=8191 immediately, no done pulse; a new start then completes normally.
